// File: rtl/serial_rx16_pkg.sv
// serial_rx16_pkg: shared state encoding and widths for the serial receiver
package serial_rx16_pkg;
    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;
endpackage

// File: rtl/serial_rx16_rx_shift16.sv
// rx_shift16: 16-bit shift-in register, direction chosen by MSB_FIRST
module rx_shift16
    import serial_rx16_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en_i,
    input  logic              bit_i,
    output logic [WORD_W-1:0] data_o
);
    logic [WORD_W-1:0] data_q;
    always_ff @(posedge clk) begin
        if (rst)
            data_q <= '0;
        else if (shift_en_i)
            data_q <= MSB_FIRST ? {data_q[WORD_W-2:0], bit_i} : {bit_i, data_q[WORD_W-1:1]};
    end
    assign data_o = data_q;
endmodule

// File: rtl/serial_rx16.sv
// serial_rx16: strobed serial frame receiver (start, 16 data, optional even parity, stop)
module serial_rx16
    import serial_rx16_pkg::*;
#(
    parameter bit PARITY_EN = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              bit_en,
    output logic [WORD_W-1:0] dout,
    output logic              valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic [WORD_W-1:0] word;
    logic              par_bad_q, par_bad_d;
    logic              valid_q, valid_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              shift_en;
    logic              stop_smp;

    rx_shift16 #(.MSB_FIRST(MSB_FIRST)) u_shift (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (shift_en),
        .bit_i      (sin),
        .data_o     (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dout_q    <= '0;
            par_bad_q <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            par_bad_q <= par_bad_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    state_d = sin ? IDLE : DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WORD_W - 1))
                        state_d = PARITY_EN ? PARITY : STOP;
                end
                PARITY: state_d = STOP;
                STOP:   state_d = IDLE;
            endcase
        end
    end

    // Pulses and dout are registered so they appear right after the stop-bit edge.
    always_comb begin
        shift_en  = bit_en && state_q == DATA;
        stop_smp  = bit_en && state_q == STOP;
        valid_d   = stop_smp && sin;
        frm_err_d = stop_smp && !sin;
        par_err_d = valid_d && par_bad_q;
        par_bad_d = (bit_en && state_q == PARITY) ? (^word ^ sin) : par_bad_q;
        dout_d    = valid_d ? word : dout_q;
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign par_err = par_err_q;
    assign frm_err = frm_err_q;
    assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_serial_rx16.sv
// tb_serial_rx16: vector table plus randomized frames checked against a word-level model
module tb_serial_rx16;
    localparam bit PARITY_EN = 1'b1;
    localparam bit MSB_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        rst, sin, bit_en;
    logic [15:0] dout;
    logic        valid, par_err, frm_err, busy;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_dout = 16'h0000;

    serial_rx16 #(.PARITY_EN(PARITY_EN), .MSB_FIRST(MSB_FIRST)) dut (
        .clk     (clk),
        .rst     (rst),
        .sin     (sin),
        .bit_en  (bit_en),
        .dout    (dout),
        .valid   (valid),
        .par_err (par_err),
        .frm_err (frm_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic        par_bit;
        logic        stop_bit;
        int          period;
        logic [15:0] exp_dout;
        logic        exp_valid;
        logic        exp_pe;
        logic        exp_fe;
    } vec_t;

    task automatic chk(input string nm, input logic [15:0] ed, input logic ev, epe, efe, eb);
        checks++;
        if (dout !== ed || valid !== ev || par_err !== epe || frm_err !== efe || busy !== eb) begin
            errors++;
            $display("FAIL %s: got dout=%h valid=%b par_err=%b frm_err=%b busy=%b, want %h %b %b %b %b",
                     nm, dout, valid, par_err, frm_err, busy, ed, ev, epe, efe, eb);
        end
    endtask

    // Called at a negedge: present one bit for one strobe, return at the following negedge.
    task automatic strobe(input logic b);
        sin = b;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        sin = 1'($urandom);
    endtask

    task automatic gap(input int n, input logic eb, input string nm);
        repeat (n) begin
            @(negedge clk);
            sin = 1'($urandom);
            chk(nm, model_dout, 1'b0, 1'b0, 1'b0, eb);
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input logic pb, sb, input int per,
                              input logic [15:0] ed, input logic ev, epe, efe, input string nm);
        strobe(1'b0);
        chk({nm, "_start"}, model_dout, 1'b0, 1'b0, 1'b0, 1'b1);
        gap(per - 1, 1'b1, {nm, "_gap"});
        for (int i = 0; i < 16; i++) begin
            strobe(MSB_FIRST ? w[15-i] : w[i]);
            chk({nm, "_data"}, model_dout, 1'b0, 1'b0, 1'b0, 1'b1);
            gap(per - 1, 1'b1, {nm, "_gap"});
        end
        if (PARITY_EN) begin
            strobe(pb);
            chk({nm, "_parity"}, model_dout, 1'b0, 1'b0, 1'b0, 1'b1);
            gap(per - 1, 1'b1, {nm, "_gap"});
        end
        strobe(sb);
        chk({nm, "_stop"}, ed, ev, epe, efe, 1'b0);
        model_dout = ed;
        gap(per - 1, 1'b0, {nm, "_post"});
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{16'h1234, 1'b1, 1'b1, 1, 16'h1234, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{16'h1234, 1'b0, 1'b1, 1, 16'h1234, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'hA5A5, 1'b0, 1'b0, 1, 16'h1234, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 1'b0, 1'b1, 4, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h0001, 1'b1, 1'b1, 4, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 1'b0, 1'b0, 2, 16'h0001, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h0000, 1'b1, 1'b1, 3, 16'h0000, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        bit_en = 1'b1;
        sin = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("reset_idle", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bit_en = 1'b0;

        for (int k = 0; k < 7; k++)
            send_frame(vecs[k].word, vecs[k].par_bit, vecs[k].stop_bit, vecs[k].period,
                       vecs[k].exp_dout, vecs[k].exp_valid, vecs[k].exp_pe, vecs[k].exp_fe,
                       $sformatf("vec%0d", k));

        // Abort a BEEF frame after its 8th data bit; reset wins over a simultaneous strobe.
        strobe(1'b0);
        chk("beef_start", model_dout, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] beef;
            beef = 16'hBEEF;
            strobe(MSB_FIRST ? beef[15-i] : beef[i]);
            chk("beef_data", model_dout, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        rst = 1'b1;
        bit_en = 1'b1;
        sin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bit_en = 1'b0;
        model_dout = 16'h0000;
        chk("beef_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        gap(3, 1'b0, "beef_quiet");
        send_frame(16'h00FF, 1'b0, 1'b1, 1, 16'h00FF, 1'b1, 1'b0, 1'b0, "after_reset");

        for (int r = 0; r < 25; r++) begin
            logic [15:0] w;
            logic        flip, sb;
            int          per;
            w    = 16'($urandom);
            flip = ($urandom % 4) == 0;
            sb   = ($urandom % 5) != 0;
            per  = 1 + int'($urandom % 3);
            repeat ($urandom % 3) begin
                strobe(1'b1);
                chk("rnd_idle", model_dout, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            send_frame(w, (^w) ^ flip, sb, per,
                       sb ? w : model_dout, sb, sb && PARITY_EN && flip, !sb,
                       $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_rx16.md
SERIAL_RX16 -- requirements
Module: serial_rx16

Interface
REQ-001 Parameter PARITY_EN, default 1: 1 = even-parity bit follows data; 0 = no parity bit.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first data bit received lands in dout[15]; 0 = first data bit lands in dout[0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sin  input  1  serial data from the upstream 16-bit shift register's serial output; idles high.
REQ-006 bit_en  input  1  bit strobe; sin is sampled only on rising clk edges where bit_en=1.
REQ-007 dout  output  16  last accepted word; holds its value until the next accepted frame.
REQ-008 valid  output  1  one-clk pulse; dout is updated in the same cycle.
REQ-009 par_err  output  1  one-clk pulse with valid when received parity is wrong.
REQ-010 frm_err  output  1  one-clk pulse when the stop bit is sampled low.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 Frame format: start bit (0), 16 data bits, parity bit if PARITY_EN=1, stop bit (1).
REQ-013 States: IDLE, DATA, PARITY, STOP.
REQ-014 All transitions and samples occur only on cycles with bit_en=1; with bit_en=0, state, counter and shift register hold.
REQ-015 IDLE: sampling sin=0 moves to DATA and clears the 4-bit bit counter; sampling sin=1 stays in IDLE.
REQ-016 DATA: each sample shifts into an internal 16-bit register in the direction set by MSB_FIRST, then increments the counter.
REQ-017 DATA: after the 16th sample (counter wraps 15->0), go to PARITY if PARITY_EN=1, otherwise go to STOP.
REQ-018 PARITY: sample the bit and store parity_bad = (XOR of 16 data bits) XOR sample; go to STOP.
REQ-019 STOP, sample=1: on that edge, load dout, assert valid=1, set par_err=parity_bad (0 when PARITY_EN=0), return to IDLE.
REQ-020 STOP, sample=0: assert frm_err=1, leave dout unchanged, valid=0, return to IDLE.
REQ-021 Latency: valid/frm_err assert on the same edge that samples the stop bit; no extra pipeline stage.
REQ-022 valid, par_err and frm_err are 0 on every cycle not defined in REQ-019/REQ-020.
REQ-023 A start bit sampled on the bit_en directly after a stop bit is accepted with no gap (back-to-back frames).
REQ-024 sin changes while bit_en=0 have no effect.

Reset
REQ-025 rst=1 on a rising edge forces: state=IDLE, counter=0, internal shift register=0, dout=16'h0000, valid=0, par_err=0, frm_err=0, busy=0.
REQ-026 rst has priority over bit_en.
REQ-027 Reset mid-frame discards the partial word and produces no pulse.
REQ-028 After reset, the block waits for a fresh start bit.

Structure
REQ-029 A shared package holds: the state encoding constants (2-bit, IDLE=0, DATA=1, PARITY=2, STOP=3), the word width (16) and the counter width (4).
REQ-030 One sub-module, rx_shift16: a 16-bit shift-in register with a shift-enable input and a direction parameter; the FSM and counter stay in the top level.

Verification
REQ-031 Reset: rst high 1 cycle, bit_en=1, sin=1 -> dout=0000, busy=0, no pulses for 20 cycles.
REQ-032 PARITY_EN=1, MSB_FIRST=1, bit_en every cycle, frame 0, 16'h1234 MSB first, parity 1, stop 1 -> dout=1234, valid=1 and par_err=0 on the 19th sample edge.
REQ-033 Same frame with parity bit 0 -> dout=1234, valid=1, par_err=1 in the same cycle.
REQ-034 Stop bit 0 on frame 16'hA5A5 -> frm_err=1, valid=0, dout keeps its previous value 1234.
REQ-035 bit_en every 4th cycle, sin toggled between strobes; back-to-back frames 16'hFFFF then 16'h0001 -> two valid pulses with exactly those values, no gap frame required.
REQ-036 rst asserted after the 8th data bit of 16'hBEEF, then a full frame 16'h00FF -> no pulse for BEEF, dout=00FF with valid=1.
